// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, qualifies lock, and releases downstream reset.
// Optional macro PLL_LOSS_FILTER_EN: lock loss in RUN must last 4 synchronised cycles.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int CNT_W            = 20
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_cnt
);
    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic sync1, locked_s, loss, inc;
`ifdef PLL_LOSS_FILTER_EN
    logic [1:0] loss_cnt;
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_cnt <= 2'd0;
        else        loss_cnt <= (state == RUN && !locked_s) ? loss_cnt + 2'd1 : 2'd0;
    end
    assign loss = !locked_s && loss_cnt == 2'd3;
`else
    assign loss = !locked_s;
`endif
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        inc      = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (force_relock || locked_s || cnt == TO_LAST) begin
                    state_nx = (!force_relock && locked_s) ? STABLE : PLL_RST;
                    cnt_nx   = '0;
                end
            end
            STABLE: begin
                if (force_relock || !locked_s || cnt == STB_LAST) begin
                    state_nx = force_relock ? PLL_RST : (!locked_s ? WAIT_LOCK : RUN);
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (force_relock || loss) state_nx = PLL_RST;
                inc = !force_relock && loss;
            end
        endcase
    end
    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLL_RST;
            cnt        <= '0;
            sync1      <= 1'b0;
            locked_s   <= 1'b0;
            pll_rst    <= 1'b1;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sync1     <= locked;
            locked_s  <= sync1;
            pll_rst   <= state_nx == PLL_RST;
            sys_reset <= state_nx != RUN;
            ready     <= state_nx == RUN;
            if (inc && relock_cnt != 8'hff) relock_cnt <= relock_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenarios for pll_lock_supervisor with small cycle counts.
module tb_pll_lock_supervisor;
    localparam int RST = 4, STB = 8, TO = 32;
`ifdef PLL_LOSS_FILTER_EN
    localparam int DIP = 4, LAT = 6;
`else
    localparam int DIP = 1, LAT = 3;
`endif
    logic refclk = 1'b0, rst_n = 1'b0, locked = 1'b0, force_relock = 1'b0;
    logic pll_rst, sys_reset, ready;
    logic [7:0] relock_cnt;
    int n_chk = 0, n_fail = 0, exp_cnt = 0;

    always #10 refclk = ~refclk;

    pll_lock_supervisor #(.PLL_RST_CYC(RST), .LOCK_STABLE_CYC(STB), .LOCK_TIMEOUT_CYC(TO), .CNT_W(20)) dut (
        .refclk(refclk), .rst_n(rst_n), .locked(locked), .force_relock(force_relock),
        .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .relock_cnt(relock_cnt)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; locked = 1'b0; force_relock = 1'b0;
        step(3);
        n_chk++;
        if ({pll_rst, sys_reset, ready} !== 3'b110) begin
            n_fail++; $display("FAIL reset_outputs got %b want 110", {pll_rst, sys_reset, ready});
        end
        n_chk++;
        if (relock_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_relock_cnt got %0d want 0", relock_cnt);
        end
    endtask

    task automatic test_power_up;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            n_chk++;
            if ({pll_rst, sys_reset, ready} !== {k < RST, 2'b10}) begin
                n_fail++; $display("FAIL power_up cycle %0d got %b want %b", k, {pll_rst, sys_reset, ready}, {k < RST, 2'b10});
            end
        end
    endtask

    task automatic test_timeout;
        for (int k = 6; k <= 76; k++) begin
            step(1);
            n_chk++;
            if (pll_rst !== ((k >= 36 && k < 40) || (k >= 72 && k < 76))) begin
                n_fail++; $display("FAIL timeout_pll_rst cycle %0d got %b want %b", k, pll_rst, (k >= 36 && k < 40) || (k >= 72 && k < 76));
            end
        end
        n_chk++;
        if (relock_cnt !== 8'd0) begin
            n_fail++; $display("FAIL timeout_relock_cnt got %0d want 0", relock_cnt);
        end
    endtask

    task automatic test_clean_lock;
        step(10);
        locked = 1'b1;
        step(10);
        n_chk++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL clean_lock_early got ready=%b want 0", ready);
        end
        step(1);
        n_chk++;
        if ({ready, sys_reset, pll_rst} !== 3'b100) begin
            n_fail++; $display("FAIL clean_lock_release got %b want 100", {ready, sys_reset, pll_rst});
        end
        n_chk++;
        if (relock_cnt !== 8'd0) begin
            n_fail++; $display("FAIL clean_lock_relock_cnt got %0d want 0", relock_cnt);
        end
    endtask

    task automatic test_force_relock;
        int t;
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        n_chk++;
        if ({pll_rst, sys_reset, ready} !== 3'b110) begin
            n_fail++; $display("FAIL force_exit got %b want 110", {pll_rst, sys_reset, ready});
        end
        for (int k = 2; k <= 5; k++) begin
            step(1);
            n_chk++;
            if (pll_rst !== (k <= RST)) begin
                n_fail++; $display("FAIL force_pulse cycle %0d got %b want %b", k, pll_rst, k <= RST);
            end
        end
        t = 0;
        while (!ready && t < 40) begin
            step(1);
            t++;
        end
        n_chk++;
        if (t !== 9) begin
            n_fail++; $display("FAIL force_relock_latency got %0d want 9", t);
        end
        n_chk++;
        if (relock_cnt !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL force_relock_cnt got %0d want %0d", relock_cnt, exp_cnt);
        end
    endtask

    task automatic test_stable_glitch;
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        step(8);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(10);
        n_chk++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL stable_glitch_early got ready=%b want 0", ready);
        end
        step(1);
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL stable_glitch_release got ready=%b want 1", ready);
        end
        n_chk++;
        if (relock_cnt !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL stable_glitch_cnt got %0d want %0d", relock_cnt, exp_cnt);
        end
    endtask

    task automatic test_run_loss;
        int t;
        locked = 1'b0;
        step(DIP);
        locked = 1'b1;
        step(LAT - 1 - DIP);
        n_chk++;
        if ({pll_rst, ready} !== 2'b01) begin
            n_fail++; $display("FAIL run_loss_early got %b want 01", {pll_rst, ready});
        end
        step(1);
        exp_cnt++;
        n_chk++;
        if ({pll_rst, sys_reset, ready} !== 3'b110) begin
            n_fail++; $display("FAIL run_loss_exit got %b want 110", {pll_rst, sys_reset, ready});
        end
        n_chk++;
        if (relock_cnt !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL run_loss_cnt got %0d want %0d", relock_cnt, exp_cnt);
        end
        t = 0;
        while (!ready && t < 40) begin
            step(1);
            t++;
        end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL run_loss_relock got ready=%b want 1", ready);
        end
    endtask

    task automatic test_dip3;
        int t;
        locked = 1'b0;
        step(3);
        locked = 1'b1;
`ifdef PLL_LOSS_FILTER_EN
        for (int k = 0; k < 12; k++) begin
            n_chk++;
            if ({ready, pll_rst} !== 2'b10) begin
                n_fail++; $display("FAIL dip3_filtered cycle %0d got %b want 10", k, {ready, pll_rst});
            end
            step(1);
        end
`else
        exp_cnt++;
        n_chk++;
        if ({pll_rst, ready} !== 2'b10) begin
            n_fail++; $display("FAIL dip3_exit got %b want 10", {pll_rst, ready});
        end
        t = 0;
        while (!ready && t < 40) begin
            step(1);
            t++;
        end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL dip3_relock got ready=%b want 1", ready);
        end
`endif
        n_chk++;
        if (relock_cnt !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL dip3_cnt got %0d want %0d", relock_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturation;
        int t;
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step(DIP);
            locked = 1'b1;
            t = 0;
            while (!pll_rst && t < 20) begin
                step(1);
                t++;
            end
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n_chk++;
            if (relock_cnt !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL saturation iter %0d got %0d want %0d", i, relock_cnt, exp_cnt);
            end
            t = 0;
            while (!ready && t < 40) begin
                step(1);
                t++;
            end
            n_chk++;
            if (ready !== 1'b1) begin
                n_fail++; $display("FAIL saturation_relock iter %0d got ready=%b want 1", i, ready);
                break;
            end
        end
        n_chk++;
        if (relock_cnt !== 8'd255) begin
            n_fail++; $display("FAIL saturation_final got %0d want 255", relock_cnt);
        end
    endtask

    task automatic test_mid_reset;
        step(2);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({pll_rst, sys_reset, ready, relock_cnt} !== {3'b110, 8'd0}) begin
            n_fail++; $display("FAIL mid_reset got %b/%0d want 110/0", {pll_rst, sys_reset, ready}, relock_cnt);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        n_chk++;
        if ({pll_rst, ready} !== 2'b10) begin
            n_fail++; $display("FAIL mid_reset_release got %b want 10", {pll_rst, ready});
        end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_timeout;
        test_clean_lock;
        test_force_relock;
        test_stable_glitch;
        test_run_loss;
        test_dip3;
        test_saturation;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
